// File: rtl/csa_accum_ctrl_if.sv
// Operand/result handshake bundle for the CSA accumulator sequencer.
// Latency: none, wires only.
// Backpressure: in_ready toward the producer, out_ready from the consumer.
interface csa_accum_ctrl_if #(
    parameter int WIDTH = 15,
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] op_count;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             overflow;

    modport master (
        output start, op_count, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, overflow
    );

    modport slave (
        input  start, op_count, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, overflow
    );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Multi-operand adder: streams operands through one 15-bit CSA row, resolves with one CPA.
// Latency: result valid 2 cycles after the last operand accept; build with CSA_OVF_EN for wrap detection.
// Backpressure: in_ready is registered and high only while accumulating; result held until out_ready.
module csa_row #(
    parameter int W = 15
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c_in,
    output logic [W-1:0] s,
    output logic [W-1:0] c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

module csa_accum_ctrl #(
    parameter int WIDTH = 15,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    csa_accum_ctrl_if.slave    io
);
    generate
        if (WIDTH != 15) begin : g_bad_width
            $error("csa_accum_ctrl: WIDTH must be 15 to match the CSA row");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] csa_s;
    logic [WIDTH-1:0] csa_c;
    logic [WIDTH-1:0] res_w;
    logic [WIDTH-1:0] out_data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             job_start;
    logic             accept;
    logic             last_accept;

    assign job_start   = (state_q == IDLE) && io.start;
    assign accept      = io.in_valid && in_ready_q;
    assign last_accept = accept && (cnt_q == CNT_W'(1));

    csa_row #(.W(WIDTH)) u_csa (
        .a     (io.in_data),
        .b     (s_q),
        .c_in  (c_q),
        .s     (csa_s),
        .c_out (csa_c)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io.start) state_d = (io.op_count == '0) ? DONE : ACCUM;
            ACCUM:   if (last_accept) state_d = RESOLVE;
            RESOLVE: state_d = DONE;
            DONE:    if (io.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == ACCUM);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    // Carry vector is shifted into its weight; the bit leaving the top is the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q        <= '0;
            c_q        <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
        end else begin
            if (job_start) begin
                s_q   <= '0;
                c_q   <= '0;
                cnt_q <= io.op_count;
                if (io.op_count == '0) out_data_q <= '0;
            end
            if (accept) begin
                s_q   <= csa_s;
                c_q   <= csa_c << 1;
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (state_q == RESOLVE) out_data_q <= res_w;
        end
    end

`ifdef CSA_OVF_EN
    logic res_carry;
    logic ovf_q;

    assign {res_carry, res_w} = {1'b0, s_q} + {1'b0, c_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (job_start) begin
            ovf_q <= 1'b0;
        end else if (accept && csa_c[WIDTH-1]) begin
            ovf_q <= 1'b1;
        end else if ((state_q == RESOLVE) && res_carry) begin
            ovf_q <= 1'b1;
        end
    end

    assign io.overflow = ovf_q;
`else
    assign res_w       = s_q + c_q;
    assign io.overflow = 1'b0;
`endif

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.busy      = busy_q;
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Randomized and directed jobs against an integer-sum job model, checked every cycle.
module tb_csa_accum_ctrl;
    localparam int WIDTH = 15;
    localparam int CNT_W = 4;
`ifdef CSA_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    csa_accum_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) io ();

    csa_accum_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Job-level model: outputs follow from the accepted operand sum.
    bit          m_in_ready = 0, m_out_valid = 0, m_busy = 0, m_ovf = 0, m_resolve = 0;
    logic [14:0] m_out_data = '0;
    int          m_rem = 0;
    longint      m_sum = 0;

    int          cyc = 0, last_acc_cyc = 0, lat = 0, ir_cnt = 0;
    bit          prev_ov = 0;
    logic [14:0] res_q[$];
    logic        ovf_q[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            chk("in_ready", 32'(io.in_ready), 32'(m_in_ready));
            chk("out_valid", 32'(io.out_valid), 32'(m_out_valid));
            chk("busy", 32'(io.busy), 32'(m_busy));
            chk("out_data", 32'(io.out_data), 32'(m_out_data));
            if (m_out_valid || !OVF_EN)
                chk("overflow", 32'(io.overflow), 32'(m_ovf));

            if (io.out_valid && !prev_ov) lat = cyc - last_acc_cyc;
            prev_ov = io.out_valid;
            if (io.in_ready) ir_cnt++;
            if (!rst && io.in_valid && io.in_ready) last_acc_cyc = cyc;
            if (!rst && io.out_valid && io.out_ready) begin
                res_q.push_back(io.out_data);
                ovf_q.push_back(io.overflow);
            end

            if (rst) begin
                m_in_ready = 0; m_out_valid = 0; m_busy = 0; m_ovf = 0; m_resolve = 0;
                m_out_data = '0; m_rem = 0; m_sum = 0;
            end else if (!m_busy) begin
                if (io.start) begin
                    m_sum  = 0;
                    m_busy = 1;
                    if (io.op_count == 0) begin
                        m_out_valid = 1; m_out_data = '0; m_ovf = 0;
                    end else begin
                        m_rem = int'(io.op_count); m_in_ready = 1;
                    end
                end
            end else if (m_in_ready) begin
                if (io.in_valid) begin
                    m_sum = m_sum + longint'(io.in_data);
                    m_rem--;
                    if (m_rem == 0) begin
                        m_in_ready = 0; m_resolve = 1;
                    end
                end
            end else if (m_resolve) begin
                m_resolve   = 0;
                m_out_valid = 1;
                m_out_data  = 15'(m_sum % 32768);
                m_ovf       = OVF_EN && (m_sum > 32767);
            end else if (m_out_valid && io.out_ready) begin
                m_out_valid = 0;
                m_busy      = 0;
            end
        end
    end

    logic [14:0] ops[16];

    task automatic pop_res(output logic [31:0] d, output logic [31:0] o);
        if (res_q.size() == 0) begin
            d = 'x;
            o = 'x;
        end else begin
            d = 32'(res_q.pop_front());
            o = 32'(ovf_q.pop_front());
        end
    endtask

    // gap < 0 picks a random 0..3 idle gap before each beat.
    task automatic feed_ops(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            int g;
            int to;
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            io.in_valid = 1'b0;
            repeat (g) tick();
            io.in_valid = 1'b1;
            io.in_data  = ops[k];
            to = 0;
            while (!io.in_ready && to < 20) begin
                tick();
                to++;
            end
            if (to >= 20) chk("accept_timeout", 32'd1, 32'd0);
            tick();
            io.in_valid = 1'b0;
        end
    endtask

    task automatic run_job(input int n, input int gap, input int rdy_wait, input bit poke);
        int to;
        io.start    = 1'b1;
        io.op_count = CNT_W'(n);
        tick();
        io.start = 1'b0;
        feed_ops(n, gap);
        to = 0;
        while (!io.out_valid && to < 20) begin
            tick();
            to++;
        end
        if (to >= 20) chk("result_timeout", 32'd1, 32'd0);
        for (int w = 0; w < rdy_wait; w++) begin
            io.start    = poke;
            io.op_count = CNT_W'($urandom_range(0, 15));
            io.in_valid = poke;
            io.in_data  = 15'($urandom);
            tick();
        end
        io.start    = 1'b0;
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        tick();
        io.out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] d, o;
        int ir0;
        io.start = 1'b0; io.op_count = '0; io.in_valid = 1'b0;
        io.in_data = '0; io.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_in_ready", 32'(io.in_ready), 32'd0);
        chk("rst_out_valid", 32'(io.out_valid), 32'd0);
        chk("rst_busy", 32'(io.busy), 32'd0);
        chk("rst_out_data", 32'(io.out_data), 32'd0);
        rst = 1'b0;
        tick();

        // 5+7+9, no gaps, check latency
        ops[0] = 15'd5; ops[1] = 15'd7; ops[2] = 15'd9;
        run_job(3, 0, 0, 1'b0);
        pop_res(d, o);
        chk("t1_res", d, 32'h15);
        chk("t1_ovf", o, 32'd0);
        chk("t1_lat", 32'(lat), 32'd2);

        // wrap to zero
        ops[0] = 15'h7FFF; ops[1] = 15'h0001;
        run_job(2, 0, 0, 1'b0);
        pop_res(d, o);
        chk("t2_res", d, 32'h0);
        chk("t2_ovf", o, 32'(OVF_EN));

        // gaps of 3 between beats
        for (int k = 0; k < 4; k++) ops[k] = 15'h1000;
        run_job(4, 3, 0, 1'b0);
        pop_res(d, o);
        chk("t3_res", d, 32'h4000);

        // consumer stall with start/in_valid pokes
        ops[0] = 15'd5; ops[1] = 15'd7; ops[2] = 15'd9;
        run_job(3, 0, 5, 1'b1);
        pop_res(d, o);
        chk("t4_res", d, 32'h15);
        chk("t4_idle", 32'(io.busy), 32'd0);
        tick();

        // reset after second accept
        for (int k = 0; k < 5; k++) ops[k] = 15'h0111;
        io.start = 1'b1; io.op_count = 4'd5;
        tick();
        io.start = 1'b0;
        feed_ops(2, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", 32'(io.busy), 32'd0);
        chk("t5_in_ready", 32'(io.in_ready), 32'd0);
        chk("t5_out_valid", 32'(io.out_valid), 32'd0);
        chk("t5_out_data", 32'(io.out_data), 32'd0);
        chk("t5_no_result", 32'(res_q.size()), 32'd0);
        ops[0] = 15'h0ABC;
        run_job(1, 0, 0, 1'b0);
        pop_res(d, o);
        chk("t5_res", d, 32'h0ABC);

        // empty job, then back-to-back start
        ops[0] = 15'h5555;
        run_job(1, 0, 0, 1'b0);
        pop_res(d, o);
        ir0 = ir_cnt;
        run_job(0, 0, 0, 1'b0);
        chk("t6_no_ready", 32'(ir_cnt - ir0), 32'd0);
        pop_res(d, o);
        chk("t6_res", d, 32'h0);
        ops[0] = 15'h0123;
        run_job(1, 0, 0, 1'b0);
        pop_res(d, o);
        chk("t6_b2b_res", d, 32'h0123);

        // random jobs; per-cycle model check covers results
        for (int j = 0; j < 40; j++) begin
            int n;
            n = int'($urandom_range(0, 15));
            for (int k = 0; k < 16; k++) ops[k] = 15'($urandom);
            run_job(n, -1, int'($urandom_range(0, 3)), 1'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        res_q.delete();
        ovf_q.delete();

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL global_timeout: got running want finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
